spad_req_serializer: RTL and testbench

//   Sits between the kernel's two scratchpad BRAM ports (address/ce/we/d/q x2) and the host access bridge.

---
 rtl/spad_req_serializer_if.sv | 26 ++
 rtl/spad_req_serializer.sv | 127 ++++++++++++
 tb/tb_spad_req_serializer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spad_req_serializer_if.sv
// Request/response stream between the scratchpad serializer and the host bridge.
// The master side produces requests and consumes read responses.
interface spad_req_serializer_if #(
   parameter int ADDR_WID = 13,
   parameter int DATA_WID = 32
);
   logic                req_valid;
   logic                req_ready;
   logic                req_we;
   logic                req_port;
   logic [ADDR_WID+1:0] req_addr;
   logic [DATA_WID-1:0] req_wdata;
   logic                rsp_valid;
   logic                rsp_port;
   logic [DATA_WID-1:0] rsp_data;

   modport master (
      output req_valid, req_we, req_port, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_port, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_port, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_port, rsp_data
   );
endinterface

// File: rtl/spad_req_serializer.sv
// Serializes two kernel BRAM ports into one in-order request stream and
// steers read responses back to the matching port's q register.
module spad_req_serializer #(
   parameter int ADDR_WID   = 13,
   parameter int DATA_WID   = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WID    = 32
) (
   input  logic                mod_clk,
   input  logic                reset,
   input  logic [ADDR_WID-1:0] addr0,
   input  logic                ce0,
   input  logic                we0,
   input  logic [DATA_WID-1:0] d0,
   output logic [DATA_WID-1:0] q0,
   input  logic [ADDR_WID-1:0] addr1,
   input  logic                ce1,
   input  logic                we1,
   input  logic [DATA_WID-1:0] d1,
   output logic [DATA_WID-1:0] q1,
   output logic                kernel_hold,
   output logic                idle,
   output logic [CNT_WID-1:0]  acc_count,
   output logic                err_ovf,
   output logic                err_rsp,
   spad_req_serializer_if.master bus
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic                we;
      logic                port;
      logic [ADDR_WID-1:0] addr;
      logic [DATA_WID-1:0] data;
   } ent_t;

   ent_t                mem_q [FIFO_DEPTH];
   ent_t                head, e0, e1;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d, outst_q, outst_d;
   logic [DATA_WID-1:0] q0_q, q0_d, q1_q, q1_d;
   logic [CNT_WID-1:0]  acc_count_q, acc_count_d;
   logic [CNT_WID:0]    acc_sum;
   logic                hold_q, hold_d;
   logic                err_ovf_q, err_ovf_d, err_rsp_q, err_rsp_d;
   logic                pop, acc0, acc1, rd_pop, rsp_ok;
   logic [1:0]          n_push;

   always_comb begin
      head    = mem_q[rd_ptr_q];
      e0      = '{we: we0, port: 1'b0, addr: addr0, data: d0};
      e1      = '{we: we1, port: 1'b1, addr: addr1, data: d1};
      pop     = (count_q != '0) && bus.req_ready;
      // Room is judged before this edge's pop frees a slot.
      acc0    = ce0 && (count_q < CW'(FIFO_DEPTH));
      acc1    = ce1 && ((count_q + CW'(acc0)) < CW'(FIFO_DEPTH));
      n_push  = {1'b0, acc0} + {1'b0, acc1};
      count_d = count_q + CW'(n_push) - CW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      rd_pop  = pop && !head.we;
      rsp_ok  = bus.rsp_valid && (outst_q != '0);
      outst_d = outst_q + CW'(rd_pop) - CW'(rsp_ok);
      q0_d    = q0_q;
      q1_d    = q1_q;
      if (rsp_ok && !bus.rsp_port) q0_d = bus.rsp_data;
      if (rsp_ok &&  bus.rsp_port) q1_d = bus.rsp_data;
      err_ovf_d = err_ovf_q
                | ((ce0 | ce1) & hold_q)
                | (ce0 & !acc0)
                | (ce1 & !acc1);
      err_rsp_d = err_rsp_q | (bus.rsp_valid & (outst_q == '0));
      acc_sum   = {1'b0, acc_count_q} + (CNT_WID+1)'(n_push);
      acc_count_d = acc_sum[CNT_WID] ? '1 : acc_sum[CNT_WID-1:0];
      hold_d = (count_d > CW'(FIFO_DEPTH-2))
             || ((outst_d != '0) && (count_d != '0));
   end

   always_ff @(posedge mod_clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         outst_q     <= '0;
         q0_q        <= '0;
         q1_q        <= '0;
         acc_count_q <= '0;
         hold_q      <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_rsp_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         outst_q     <= outst_d;
         q0_q        <= q0_d;
         q1_q        <= q1_d;
         acc_count_q <= acc_count_d;
         hold_q      <= hold_d;
         err_ovf_q   <= err_ovf_d;
         err_rsp_q   <= err_rsp_d;
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge mod_clk) begin
      if (acc0) mem_q[wr_ptr_q] <= e0;
      if (acc1) mem_q[wr_ptr_q + PW'(acc0)] <= e1;
   end

   assign bus.req_valid = (count_q != '0);
   assign bus.req_we    = head.we;
   assign bus.req_port  = head.port;
   assign bus.req_addr  = {head.addr, 2'b00};
   assign bus.req_wdata = head.data;

   assign q0          = q0_q;
   assign q1          = q1_q;
   assign kernel_hold = hold_q;
   assign idle        = (count_q == '0) && (outst_q == '0);
   assign acc_count   = acc_count_q;
   assign err_ovf     = err_ovf_q;
   assign err_rsp     = err_rsp_q;

endmodule

// File: tb/tb_spad_req_serializer.sv
// Self-checking bench: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_spad_req_serializer;

   localparam int AW    = 13;
   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic          mod_clk;
   logic          reset;
   logic [AW-1:0] addr0, addr1;
   logic          ce0, we0, ce1, we1;
   logic [DW-1:0] d0, d1, q0, q1;
   logic          kernel_hold, idle, err_ovf, err_rsp;
   logic [31:0]   acc_count;

   int n_chk  = 0;
   int n_pass = 0;

   spad_req_serializer_if #(.ADDR_WID(AW), .DATA_WID(DW)) bus ();

   spad_req_serializer #(
      .ADDR_WID(AW), .DATA_WID(DW), .FIFO_DEPTH(DEPTH), .CNT_WID(32)
   ) dut (
      .mod_clk(mod_clk), .reset(reset),
      .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0),
      .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1),
      .kernel_hold(kernel_hold), .idle(idle), .acc_count(acc_count),
      .err_ovf(err_ovf), .err_rsp(err_rsp), .bus(bus)
   );

   initial mod_clk = 1'b0;
   always #5 mod_clk = ~mod_clk;

   typedef struct {
      logic ce0, we0; logic [AW-1:0] a0; logic [DW-1:0] d0;
      logic ce1, we1; logic [AW-1:0] a1; logic [DW-1:0] d1;
      logic rdy, rv, rp; logic [DW-1:0] rd;
      logic e_valid, e_we, e_port; logic [AW+1:0] e_addr;
      logic [DW-1:0] e_wd; logic e_hold, e_idle;
      logic [DW-1:0] e_q0, e_q1; logic [31:0] e_acc;
   } vec_t;

   typedef struct {
      logic we; logic port; logic [AW-1:0] addr; logic [DW-1:0] data;
   } ment_t;

   vec_t  tv [8];
   ment_t mq [$];
   int    m_out;
   logic [DW-1:0] m_q0, m_q1;
   logic [31:0]   m_acc;
   logic          m_ovf, m_rsp;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge mod_clk);
      #1;
   endtask

   task automatic set_in(logic c0, logic w0, logic [AW-1:0] a0,
                         logic [DW-1:0] dd0, logic c1, logic w1,
                         logic [AW-1:0] a1, logic [DW-1:0] dd1,
                         logic rdy, logic rv, logic rp,
                         logic [DW-1:0] rd);
      ce0 = c0; we0 = w0; addr0 = a0; d0 = dd0;
      ce1 = c1; we1 = w1; addr1 = a1; d1 = dd1;
      bus.req_ready = rdy; bus.rsp_valid = rv;
      bus.rsp_port = rp; bus.rsp_data = rd;
   endtask

   task automatic idle_in(logic rdy);
      set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0,
             rdy, 1'b0, 1'b0, '0);
   endtask

   task automatic do_reset();
      idle_in(1'b0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   function automatic bit m_hold();
      return (mq.size() > DEPTH-2) || (m_out != 0 && mq.size() != 0);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_out = 0; m_q0 = '0; m_q1 = '0; m_acc = '0;
      m_ovf = 1'b0; m_rsp = 1'b0;
   endtask

   task automatic model_step();
      int    n;
      bit    a0, a1, drop, popped;
      ment_t hd;
      n = mq.size();
      popped = (n != 0) && bus.req_ready;
      a0 = 0; a1 = 0; drop = 0;
      if (ce0) begin
         if (n < DEPTH) a0 = 1; else drop = 1;
      end
      if (ce1) begin
         if (n + int'(a0) < DEPTH) a1 = 1; else drop = 1;
      end
      if (((ce0 || ce1) && m_hold()) || drop) m_ovf = 1'b1;
      if (bus.rsp_valid) begin
         if (m_out == 0) m_rsp = 1'b1;
         else begin
            if (bus.rsp_port) m_q1 = bus.rsp_data;
            else m_q0 = bus.rsp_data;
            m_out--;
         end
      end
      if (popped) begin
         hd = mq.pop_front();
         if (!hd.we) m_out++;
      end
      if (a0) mq.push_back('{we0, 1'b0, addr0, d0});
      if (a1) mq.push_back('{we1, 1'b1, addr1, d1});
      m_acc = m_acc + 32'(a0) + 32'(a1);
   endtask

   task automatic model_check();
      chk("r_valid", 64'(bus.req_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("r_we", 64'(bus.req_we), 64'(mq[0].we));
         chk("r_port", 64'(bus.req_port), 64'(mq[0].port));
         chk("r_addr", 64'(bus.req_addr), 64'(mq[0].addr) * 4);
         if (mq[0].we)
            chk("r_wdata", 64'(bus.req_wdata), 64'(mq[0].data));
      end
      chk("r_hold", 64'(kernel_hold), 64'(m_hold()));
      chk("r_idle", 64'(idle), 64'(mq.size() == 0 && m_out == 0));
      chk("r_q0", 64'(q0), 64'(m_q0));
      chk("r_q1", 64'(q1), 64'(m_q1));
      chk("r_acc", 64'(acc_count), 64'(m_acc));
      chk("r_ovf", 64'(err_ovf), 64'(m_ovf));
      chk("r_rsp", 64'(err_rsp), 64'(m_rsp));
   endtask

   initial begin
      reset = 1'b0;
      idle_in(1'b0);
      // dual read, responses, then write pass-through
      tv[0] = '{1'b1, 1'b0, 13'd5, 32'h0, 1'b1, 1'b0, 13'd9, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 15'd0, 32'h0, 1'b0, 1'b1,
                32'h0, 32'h0, 32'd0};
      tv[1] = '{1'b0, 1'b0, 13'd0, 32'h0, 1'b0, 1'b0, 13'd0, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 1'b0, 15'd20, 32'h0, 1'b0, 1'b0,
                32'h0, 32'h0, 32'd2};
      tv[2] = '{1'b0, 1'b0, 13'd0, 32'h0, 1'b0, 1'b0, 13'd0, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 1'b1, 15'd36, 32'h0, 1'b1, 1'b0,
                32'h0, 32'h0, 32'd2};
      tv[3] = '{1'b0, 1'b0, 13'd0, 32'h0, 1'b0, 1'b0, 13'd0, 32'h0,
                1'b1, 1'b1, 1'b0, 32'hAA,
                1'b0, 1'b0, 1'b0, 15'd0, 32'h0, 1'b0, 1'b0,
                32'h0, 32'h0, 32'd2};
      tv[4] = '{1'b0, 1'b0, 13'd0, 32'h0, 1'b0, 1'b0, 13'd0, 32'h0,
                1'b1, 1'b1, 1'b1, 32'hBB,
                1'b0, 1'b0, 1'b0, 15'd0, 32'h0, 1'b0, 1'b0,
                32'hAA, 32'h0, 32'd2};
      tv[5] = '{1'b1, 1'b1, 13'd3, 32'h1234, 1'b0, 1'b0, 13'd0, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 15'd0, 32'h0, 1'b0, 1'b1,
                32'hAA, 32'hBB, 32'd2};
      tv[6] = '{1'b0, 1'b0, 13'd0, 32'h0, 1'b0, 1'b0, 13'd0, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b1, 1'b0, 15'd12, 32'h1234, 1'b0, 1'b0,
                32'hAA, 32'hBB, 32'd3};
      tv[7] = '{1'b0, 1'b0, 13'd0, 32'h0, 1'b0, 1'b0, 13'd0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 15'd0, 32'h0, 1'b0, 1'b1,
                32'hAA, 32'hBB, 32'd3};

      // T1: reset state
      do_reset();
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_valid", 64'(bus.req_valid), 64'd0);
      chk("rst_hold", 64'(kernel_hold), 64'd0);
      chk("rst_q0", 64'(q0), 64'd0);
      chk("rst_q1", 64'(q1), 64'd0);
      chk("rst_acc", 64'(acc_count), 64'd0);
      chk("rst_err", 64'({err_ovf, err_rsp}), 64'd0);

      // T2/T3 table
      for (int i = 0; i < 8; i++) begin
         set_in(tv[i].ce0, tv[i].we0, tv[i].a0, tv[i].d0,
                tv[i].ce1, tv[i].we1, tv[i].a1, tv[i].d1,
                tv[i].rdy, tv[i].rv, tv[i].rp, tv[i].rd);
         #1;
         chk($sformatf("v%0d_valid", i), 64'(bus.req_valid),
             64'(tv[i].e_valid));
         if (tv[i].e_valid) begin
            chk($sformatf("v%0d_we", i), 64'(bus.req_we), 64'(tv[i].e_we));
            chk($sformatf("v%0d_port", i), 64'(bus.req_port),
                64'(tv[i].e_port));
            chk($sformatf("v%0d_addr", i), 64'(bus.req_addr),
                64'(tv[i].e_addr));
            if (tv[i].e_we)
               chk($sformatf("v%0d_wdata", i), 64'(bus.req_wdata),
                   64'(tv[i].e_wd));
         end
         chk($sformatf("v%0d_hold", i), 64'(kernel_hold), 64'(tv[i].e_hold));
         chk($sformatf("v%0d_idle", i), 64'(idle), 64'(tv[i].e_idle));
         chk($sformatf("v%0d_q0", i), 64'(q0), 64'(tv[i].e_q0));
         chk($sformatf("v%0d_q1", i), 64'(q1), 64'(tv[i].e_q1));
         chk($sformatf("v%0d_acc", i), 64'(acc_count), 64'(tv[i].e_acc));
         tick();
      end

      // T4: backpressure fills FIFO, extra push at full overflows
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, 1'b1, AW'(2*k), DW'(32'h100 + 2*k),
                1'b1, 1'b1, AW'(2*k+1), DW'(32'h101 + 2*k),
                1'b0, 1'b0, 1'b0, '0);
         #1;
         chk($sformatf("bp%0d_hold", k), 64'(kernel_hold), 64'd0);
         tick();
      end
      set_in(1'b1, 1'b1, 13'd100, 32'hDEAD, 1'b1, 1'b1, 13'd101,
             32'hBEEF, 1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("bp_full_hold", 64'(kernel_hold), 64'd1);
      chk("bp_pre_ovf", 64'(err_ovf), 64'd0);
      tick();
      idle_in(1'b0);
      #1;
      chk("bp_ovf", 64'(err_ovf), 64'd1);
      chk("bp_acc", 64'(acc_count), 64'd8);
      for (int k = 0; k < 8; k++) begin
         idle_in(1'b1);
         #1;
         chk($sformatf("bp_drain%0d_valid", k), 64'(bus.req_valid), 64'd1);
         chk($sformatf("bp_drain%0d_addr", k), 64'(bus.req_addr),
             64'(k * 4));
         chk($sformatf("bp_drain%0d_port", k), 64'(bus.req_port),
             64'(k % 2));
         chk($sformatf("bp_drain%0d_wd", k), 64'(bus.req_wdata),
             64'(32'h100 + k));
         tick();
      end
      idle_in(1'b0);
      #1;
      chk("bp_empty", 64'(bus.req_valid), 64'd0);
      chk("bp_idle", 64'(idle), 64'd1);

      // T5: push and pop on the same edge at count 3
      do_reset();
      set_in(1'b1, 1'b1, 13'd40, 32'h40, 1'b1, 1'b1, 13'd41, 32'h41,
             1'b0, 1'b0, 1'b0, '0);
      tick();
      set_in(1'b1, 1'b1, 13'd42, 32'h42, 1'b0, 1'b0, '0, '0,
             1'b0, 1'b0, 1'b0, '0);
      tick();
      set_in(1'b1, 1'b1, 13'd43, 32'h43, 1'b0, 1'b0, '0, '0,
             1'b1, 1'b0, 1'b0, '0);
      #1;
      chk("pp_head0", 64'(bus.req_addr), 64'(40 * 4));
      tick();
      for (int k = 0; k < 3; k++) begin
         idle_in(1'b1);
         #1;
         chk($sformatf("pp_drain%0d", k), 64'(bus.req_addr),
             64'((41 + k) * 4));
         tick();
      end
      idle_in(1'b0);
      #1;
      chk("pp_empty", 64'(bus.req_valid), 64'd0);

      // T6: spurious response, then reset mid-drain
      do_reset();
      set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0,
             1'b0, 1'b1, 1'b0, 32'h55);
      tick();
      idle_in(1'b0);
      #1;
      chk("sp_err_rsp", 64'(err_rsp), 64'd1);
      chk("sp_q0", 64'(q0), 64'd0);
      chk("sp_q1", 64'(q1), 64'd0);
      set_in(1'b1, 1'b0, 13'd7, '0, 1'b1, 1'b0, 13'd8, '0,
             1'b0, 1'b0, 1'b0, '0);
      tick();
      idle_in(1'b1);
      tick();
      idle_in(1'b0);
      #1;
      chk("md_hold", 64'(kernel_hold), 64'd1);
      chk("md_busy", 64'(idle), 64'd0);
      reset = 1'b1;
      #1;
      chk("md_idle", 64'(idle), 64'd1);
      chk("md_valid", 64'(bus.req_valid), 64'd0);
      chk("md_hold0", 64'(kernel_hold), 64'd0);
      chk("md_err", 64'({err_ovf, err_rsp}), 64'd0);
      chk("md_acc", 64'(acc_count), 64'd0);
      #1;
      reset = 1'b0;
      tick();

      // randomized run against the reference model
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         logic c0, c1, rv;
         if (m_hold()) begin
            c0 = ($urandom % 16) == 0;
            c1 = ($urandom % 16) == 0;
         end else begin
            c0 = 1'($urandom);
            c1 = 1'($urandom);
         end
         if (m_out > 0) rv = 1'($urandom);
         else rv = ($urandom % 32) == 0;
         set_in(c0, 1'($urandom), AW'($urandom_range(0, 8191)), $urandom,
                c1, 1'($urandom), AW'($urandom_range(0, 8191)), $urandom,
                ($urandom % 4) != 0, rv, 1'($urandom), $urandom);
         #1;
         model_check();
         model_step();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
